cpu_ctrl_fsm: RTL

- Controller stage directly downstream of the instruction register/decoder in the cpu.
- Consumes the decoded opcode/op fields and sequences the lab datapath (register file, A/B/C registers, shifter, ALU, status register).
- Emits one datapath control vector per cycle and the w ("waiting for next instruction") handshake.
- Moore FSM: every output is a pure function of the current state.

---
 rtl/cpu_ctrl_pkg.sv | 65 ++++++
 rtl/cpu_ctrl_if.sv | 38 +++
 rtl/cpu_ctrl_outdec.sv | 52 +++++
 rtl/cpu_ctrl_fsm.sv | 99 +++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the cpu controller FSM.
// Build option: CPU_CTRL_ILLEGAL_TRAP_EN adds the HALT state and the illegal flag.
package cpu_ctrl_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WRITE_IMM,
        GET_A,
        GET_B,
        EXEC,
        WRITE_REG
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_e;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

    // MOV reg and MVN are both computed as 0 <op> B.
    function automatic logic zero_a_input(input logic [2:0] opc, input logic [1:0] op);
        return ((opc == OPC_MOV) && (op == OP_MOV_REG)) ||
               ((opc == OPC_ALU) && (op == OP_MVN));
    endfunction

    function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] op);
        return (opc == OPC_ALU) && (op == OP_CMP);
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Decoder-to-controller handshake and datapath control bundle.
// Build option: CPU_CTRL_ILLEGAL_TRAP_EN adds the illegal flag.
interface cpu_ctrl_if;

    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    modport master (
        output s, opcode, op,
        input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

endinterface

// File: rtl/cpu_ctrl_outdec.sv
// Moore output decoder: state plus latched instruction fields -> control vector.
// Build option: CPU_CTRL_ILLEGAL_TRAP_EN decodes the HALT state.
module cpu_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [2:0] opc,
    input  logic [1:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            WAIT: ctrl.w = 1'b1;
            WRITE_IMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM;
                ctrl.write = 1'b1;
            end
            GET_A: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            GET_B: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            EXEC: begin
                ctrl.asel = zero_a_input(opc, op);
                if (is_cmp(opc, op)) begin
                    ctrl.loads = 1'b1;
                end else begin
                    ctrl.loadc = 1'b1;
                end
            end
            WRITE_REG: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_C;
                ctrl.write = 1'b1;
            end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            HALT: begin
                ctrl.w       = 1'b1;
                ctrl.illegal = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencing controller: latches opcode/op on leaving WAIT, steps the datapath.
// Build option: CPU_CTRL_ILLEGAL_TRAP_EN traps unsupported encodings in HALT.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
)
(
    input  logic      clk,
    input  logic      reset,
    cpu_ctrl_if.slave bus
);

    logic [STATE_W-1:0] state_q;
    state_e             state;
    state_e             state_d;
    logic [2:0]         opc_q, opc_d;
    logic [1:0]         op_q, op_d;
    ctrl_t              ctrl_q, ctrl_d;

    assign state = state_e'(state_q);

    always_comb begin
        state_d = state;
        opc_d   = opc_q;
        op_d    = op_q;
        unique case (state)
            WAIT: begin
                if (bus.s) begin
                    state_d = DECODE;
                    opc_d   = bus.opcode;
                    op_d    = bus.op;
                end
            end
            DECODE: begin
                unique case ({opc_q, op_q})
                    {OPC_MOV, OP_MOV_IMM}: state_d = WRITE_IMM;
                    {OPC_MOV, OP_MOV_REG}: state_d = GET_B;
                    {OPC_ALU, OP_ADD},
                    {OPC_ALU, OP_CMP},
                    {OPC_ALU, OP_AND}:     state_d = GET_A;
                    {OPC_ALU, OP_MVN}:     state_d = GET_B;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    default:               state_d = HALT;
`else
                    default:               state_d = WAIT;
`endif
                endcase
            end
            WRITE_IMM: state_d = WAIT;
            GET_A:     state_d = GET_B;
            GET_B:     state_d = EXEC;
            EXEC:      state_d = is_cmp(opc_q, op_q) ? WAIT : WRITE_REG;
            WRITE_REG: state_d = WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            HALT:      state_d = HALT;
`endif
            default:   state_d = WAIT;
        endcase
    end

    // Outputs are registered by decoding the next state, so they stay a pure function of state_q.
    cpu_ctrl_outdec u_outdec (
        .state (state_d),
        .opc   (opc_d),
        .op    (op_d),
        .ctrl  (ctrl_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_W'(WAIT);
            opc_q    <= '0;
            op_q     <= '0;
            ctrl_q   <= '0;
            ctrl_q.w <= 1'b1;
        end else begin
            state_q <= STATE_W'(state_d);
            opc_q   <= opc_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.w     = ctrl_q.w;
    assign bus.nsel  = ctrl_q.nsel;
    assign bus.loada = ctrl_q.loada;
    assign bus.loadb = ctrl_q.loadb;
    assign bus.loadc = ctrl_q.loadc;
    assign bus.loads = ctrl_q.loads;
    assign bus.asel  = ctrl_q.asel;
    assign bus.bsel  = ctrl_q.bsel;
    assign bus.vsel  = ctrl_q.vsel;
    assign bus.write = ctrl_q.write;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal = ctrl_q.illegal;
`endif

endmodule
